// File: rtl/result_nibble_display_pkg.sv
// result_nibble_display_pkg: shared state codes and default widths for the
// nibble-serial result display (and its sibling operand loader).
// The led_index output reuses the state code directly, so keep them aligned.
package result_nibble_display_pkg;

  localparam int DATA_W_DEF   = 7;
  localparam int NIBBLE_W_DEF = 4;

  // Code values double as the led_index shown to the user.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SHOW_LO   = 2'd1,
    ST_SHOW_HI   = 2'd2,
    ST_SHOW_FLAG = 2'd3
  } state_t;

endpackage

// File: rtl/result_nibble_display_rise.sv
// rise_edge_detect: single-cycle rising-edge pulse from an already
// synchronised level.
// Ports: clk, reset (async, active-high), level_in, rise_out.
// The history register resets to 1, so a level held high through reset
// produces no pulse.
module rise_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level_in,
  output logic rise_out
);

  logic prev_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= level_in;
    end
  end

  assign rise_out = level_in & ~prev_q;

endmodule

// File: rtl/result_nibble_display.sv
// result_nibble_display: accepts one result + overflow flag via valid/ready,
// then steps it onto a 4-bit LED field on each rotation rising edge:
// low nibble, high bits (zero padded), overflow flag, then back to idle.
// Ports: clk, reset (async, active-high), rotation_event, clear,
//        res_valid/res_data/res_ovf/res_ready (input handshake),
//        led_nibble, led_index, busy, done (all registered).
// DATA_W must satisfy NIBBLE_W < DATA_W <= 2*NIBBLE_W.
module result_nibble_display
  import result_nibble_display_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NIBBLE_W = NIBBLE_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                rotation_event,
  input  logic                clear,
  input  logic                res_valid,
  input  logic [DATA_W-1:0]   res_data,
  input  logic                res_ovf,
  output logic                res_ready,
  output logic [NIBBLE_W-1:0] led_nibble,
  output logic [1:0]          led_index,
  output logic                busy,
  output logic                done
);

  logic rise;

  rise_edge_detect u_rise (
    .clk      (clk),
    .reset    (reset),
    .level_in (rotation_event),
    .rise_out (rise)
  );

  state_t              state_q, state_n;
  logic [DATA_W-1:0]   data_q,  data_n;
  logic                ovf_q,   ovf_n;
  logic [NIBBLE_W-1:0] nib_q,   nib_n;
  logic                done_q,  done_n;
  logic                ready_q, busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      nib_q   <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      data_q  <= data_n;
      ovf_q   <= ovf_n;
      nib_q   <= nib_n;
      done_q  <= done_n;
      // Decoded from the next state so these flags flip on the same edge
      // as led_index rather than a cycle later.
      ready_q <= (state_n == ST_IDLE);
      busy_q  <= (state_n != ST_IDLE);
    end
  end

  always_comb begin
    state_n = state_q;
    data_n  = data_q;
    ovf_n   = ovf_q;
    nib_n   = nib_q;
    done_n  = 1'b0;

    if (clear) begin
      // Abort wins over everything; shadow registers are left stale.
      state_n = ST_IDLE;
      nib_n   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // A rotation rise coinciding with capture is deliberately dropped:
          // the low nibble must be seen before the first step.
          if (res_valid) begin
            data_n  = res_data;
            ovf_n   = res_ovf;
            nib_n   = res_data[NIBBLE_W-1:0];
            state_n = ST_SHOW_LO;
          end
        end
        ST_SHOW_LO: begin
          if (rise) begin
            nib_n   = NIBBLE_W'(data_q[DATA_W-1:NIBBLE_W]);
            state_n = ST_SHOW_HI;
          end
        end
        ST_SHOW_HI: begin
          if (rise) begin
            nib_n   = NIBBLE_W'(ovf_q);
            state_n = ST_SHOW_FLAG;
          end
        end
        ST_SHOW_FLAG: begin
          if (rise) begin
            nib_n   = '0;
            done_n  = 1'b1;
            state_n = ST_IDLE;
          end
        end
        default: begin
          state_n = ST_IDLE;
          nib_n   = '0;
        end
      endcase
    end
  end

  assign res_ready  = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign led_nibble = nib_q;
  assign led_index  = state_q;

endmodule
